// File: rtl/rdi_pkg.sv
// rdi_pkg: RDI state encodings and the endpoint's internal link FSM states.
package rdi_pkg;

    typedef enum logic [3:0] {
        REQ_NOP       = 4'h0,
        REQ_ACTIVE    = 4'h1,
        REQ_L1        = 4'h4,
        REQ_L2        = 4'h8,
        REQ_LINKRESET = 4'h9,
        REQ_LINKERROR = 4'hA,
        REQ_RETRAIN   = 4'hB,
        REQ_DISABLED  = 4'hC
    } state_req_e;

    typedef enum logic [3:0] {
        STS_RESET     = 4'h0,
        STS_ACTIVE    = 4'h1,
        STS_L1        = 4'h4,
        STS_L2        = 4'h8,
        STS_LINKRESET = 4'h9,
        STS_LINKERROR = 4'hA,
        STS_RETRAIN   = 4'hB,
        STS_DISABLED  = 4'hC
    } state_sts_e;

    typedef enum logic [2:0] {
        S_RESET,
        S_TRAIN,
        S_ACTIVE,
        S_STALL,
        S_RETRAIN,
        S_LINKERROR
    } fsm_e;

    // STALL still reports ACTIVE to the adapter; TRAIN still reports RESET.
    function automatic state_sts_e sts_of(fsm_e s);
        return (s == S_ACTIVE || s == S_STALL) ? STS_ACTIVE :
               (s == S_RETRAIN)                ? STS_RETRAIN :
               (s == S_LINKERROR)              ? STS_LINKERROR : STS_RESET;
    endfunction

endpackage

// File: rtl/rdi_phy_endpoint_if.sv
// rdi_phy_endpoint_if: adapter-facing lp_*/pl_* signal bundle of the RDI link.
interface rdi_phy_endpoint_if #(
    parameter int NBYTES = 8
);
    logic                  lp_irdy;
    logic                  lp_valid;
    logic [NBYTES*8-1:0]   lp_data;
    logic                  pl_trdy;
    logic                  pl_valid;
    logic [NBYTES*8-1:0]   pl_data;
    logic [3:0]            lp_state_req;
    logic                  lp_linkerror;
    logic [3:0]            pl_state_sts;
    logic                  pl_trainerror;
    logic                  pl_phyinrecenter;
    logic                  pl_stallreq;
    logic                  lp_stallack;

    modport master (
        output lp_irdy, lp_valid, lp_data, lp_state_req, lp_linkerror, lp_stallack,
        input  pl_trdy, pl_valid, pl_data, pl_state_sts, pl_trainerror, pl_phyinrecenter, pl_stallreq
    );

    modport slave (
        input  lp_irdy, lp_valid, lp_data, lp_state_req, lp_linkerror, lp_stallack,
        output pl_trdy, pl_valid, pl_data, pl_state_sts, pl_trainerror, pl_phyinrecenter, pl_stallreq
    );
endinterface

// File: rtl/rdi_tx_fifo.sv
// rdi_tx_fifo: power-of-two TX FIFO with synchronous flush; push while full is accepted only alongside a pop.
module rdi_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/rdi_phy_endpoint.sv
// rdi_phy_endpoint: PHY end of the RDI link -- link FSM, training timeout,
// stall handshake, TX FIFO toward the serializer and registered RX path.
module rdi_phy_endpoint
    import rdi_pkg::*;
#(
    parameter int NBYTES        = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int TRAIN_TIMEOUT = 1024
) (
    input  logic                lclk,
    input  logic                rst_n,
    rdi_phy_endpoint_if.slave   lp,
    output logic                phy_tx_valid,
    output logic [NBYTES*8-1:0] phy_tx_data,
    input  logic                phy_tx_ready,
    input  logic                phy_rx_valid,
    input  logic [NBYTES*8-1:0] phy_rx_data,
    output logic                phy_train_start,
    input  logic                phy_train_done,
    input  logic                phy_train_fail,
    input  logic                phy_retrain_req
);
    localparam int W  = NBYTES * 8;
    localparam int CW = $clog2(TRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TRAIN_TIMEOUT - 1);

    fsm_e          state_q, state_d;
    state_sts_e    sts_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d, terr_q, terr_d;
    logic          rxv_q;
    logic [W-1:0]  rxd_q;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        terr_d  = 1'b0;
        case (state_q)
            S_RESET: if (lp.lp_state_req == REQ_ACTIVE) begin
                state_d = S_TRAIN;
                start_d = 1'b1;
                cnt_d   = '0;
            end
            S_TRAIN, S_RETRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (phy_train_done) state_d = S_ACTIVE;
                else if (phy_train_fail || cnt_q == TO_MAX) begin
                    state_d = S_LINKERROR;
                    terr_d  = 1'b1;
                end
            end
            S_ACTIVE: if (lp.lp_state_req == REQ_RETRAIN || phy_retrain_req) state_d = S_STALL;
            S_STALL: if (lp.lp_stallack && fifo_empty) begin
                state_d = S_RETRAIN;
                start_d = 1'b1;
                cnt_d   = '0;
            end
            S_LINKERROR: if (!lp.lp_linkerror && lp.lp_state_req == REQ_NOP) state_d = S_RESET;
            default: state_d = S_RESET;
        endcase
        // Adapter link error overrides every other transition, training completion included.
        if (lp.lp_linkerror) begin
            state_d = S_LINKERROR;
            start_d = 1'b0;
            terr_d  = 1'b0;
        end
    end

    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            sts_q   <= STS_RESET;
            cnt_q   <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            rxv_q   <= 1'b0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            sts_q   <= sts_of(state_d);
            cnt_q   <= cnt_d;
            start_q <= start_d;
            terr_q  <= terr_d;
            rxv_q   <= phy_rx_valid && sts_q == STS_ACTIVE;
            if (phy_rx_valid && sts_q == STS_ACTIVE) rxd_q <= phy_rx_data;
        end
    end

    assign lp.pl_stallreq      = state_q == S_STALL;
    assign lp.pl_trdy          = sts_q == STS_ACTIVE && !fifo_full && !lp.pl_stallreq;
    assign lp.pl_state_sts     = sts_q;
    assign lp.pl_trainerror    = terr_q;
    assign lp.pl_phyinrecenter = state_q == S_TRAIN || state_q == S_RETRAIN;
    assign lp.pl_valid         = rxv_q;
    assign lp.pl_data          = rxd_q;
    assign phy_train_start     = start_q;
    assign phy_tx_valid        = !fifo_empty;

    assign fifo_push  = lp.lp_valid && lp.lp_irdy && lp.pl_trdy;
    assign fifo_pop   = phy_tx_valid && phy_tx_ready;
    assign fifo_flush = state_d == S_LINKERROR && state_q != S_LINKERROR;

    rdi_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk   (lclk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (lp.lp_data),
        .dout  (phy_tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_rdi_phy_endpoint.sv
// tb_rdi_phy_endpoint: directed checks of bring-up, TX FIFO, stall/retrain, link error, timeout and RX.
module tb_rdi_phy_endpoint;
    logic lclk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 lclk = ~lclk;

    rdi_phy_endpoint_if #(.NBYTES(8)) ifa ();
    rdi_phy_endpoint_if #(.NBYTES(8)) ifb ();

    logic        tx_valid, tx_ready, rx_valid, train_start, train_done, train_fail, retrain_req;
    logic [63:0] tx_data, rx_data;
    logic        b_tx_valid, b_train_start;
    logic [63:0] b_tx_data;

    rdi_phy_endpoint #(.NBYTES(8), .FIFO_DEPTH(4), .TRAIN_TIMEOUT(1024)) dut (
        .lclk(lclk), .rst_n(rst_n), .lp(ifa.slave),
        .phy_tx_valid(tx_valid), .phy_tx_data(tx_data), .phy_tx_ready(tx_ready),
        .phy_rx_valid(rx_valid), .phy_rx_data(rx_data), .phy_train_start(train_start),
        .phy_train_done(train_done), .phy_train_fail(train_fail), .phy_retrain_req(retrain_req)
    );

    rdi_phy_endpoint #(.NBYTES(8), .FIFO_DEPTH(4), .TRAIN_TIMEOUT(16)) dut_to (
        .lclk(lclk), .rst_n(rst_n), .lp(ifb.slave),
        .phy_tx_valid(b_tx_valid), .phy_tx_data(b_tx_data), .phy_tx_ready(1'b0),
        .phy_rx_valid(1'b0), .phy_rx_data(64'h0), .phy_train_start(b_train_start),
        .phy_train_done(1'b0), .phy_train_fail(1'b0), .phy_retrain_req(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge lclk);
        #1;
    endtask

    function automatic logic [63:0] beat(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k);
    endfunction

    logic [63:0] exp_q[$];
    int rec, starts, sts_bad, k, pops, first_a, pulses;

    initial begin
        rst_n = 1'b0;
        {tx_ready, rx_valid, train_done, train_fail, retrain_req} = '0;
        rx_data = '0;
        ifa.lp_irdy = 1'b1; ifa.lp_valid = 1'b0; ifa.lp_data = '0;
        ifa.lp_state_req = 4'h0; ifa.lp_linkerror = 1'b0; ifa.lp_stallack = 1'b0;
        ifb.lp_irdy = 1'b1; ifb.lp_valid = 1'b0; ifb.lp_data = '0;
        ifb.lp_state_req = 4'h0; ifb.lp_linkerror = 1'b0; ifb.lp_stallack = 1'b0;
        step();
        step();
        chk("rst_sts", 64'(ifa.pl_state_sts), 64'h0);
        chk("rst_trdy", 64'(ifa.pl_trdy), 64'h0);
        chk("rst_txv", 64'(tx_valid), 64'h0);
        chk("rst_outs", 64'({ifa.pl_valid, ifa.pl_stallreq, ifa.pl_trainerror, ifa.pl_phyinrecenter, train_start}), 64'h0);
        rst_n = 1'b1;

        // RX dropped in RESET
        rx_valid = 1'b1; rx_data = 64'h55;
        step();
        chk("rx_reset_drop", 64'(ifa.pl_valid), 64'h0);
        rx_valid = 1'b0;

        // Bring-up with 20 training cycles
        ifa.lp_state_req = 4'h1;
        step();
        ifa.lp_state_req = 4'h0;
        rec = 0; starts = 0; sts_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ifa.pl_phyinrecenter) break;
            rec++;
            starts += int'(train_start);
            if (ifa.pl_state_sts != 4'h0) sts_bad++;
            if (rec == 20) train_done = 1'b1;
            step();
        end
        train_done = 1'b0;
        chk("bu_recenter_cycles", 64'(rec), 64'd20);
        chk("bu_start_pulses", 64'(starts), 64'd1);
        chk("bu_sts_train", 64'(sts_bad), 64'd0);
        chk("bu_sts_active", 64'(ifa.pl_state_sts), 64'h1);

        // RX in ACTIVE: one-cycle latency
        rx_valid = 1'b1; rx_data = 64'hA1;
        step();
        chk("rx_v1", 64'(ifa.pl_valid), 64'h1);
        chk("rx_d1", ifa.pl_data, 64'hA1);
        rx_data = 64'hA2;
        step();
        chk("rx_d2", ifa.pl_data, 64'hA2);
        rx_valid = 1'b0;
        step();
        chk("rx_v_off", 64'(ifa.pl_valid), 64'h0);

        // TX backpressure: 6 beats offered into a 4-deep FIFO
        tx_ready = 1'b0; k = 0;
        ifa.lp_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ifa.lp_data = beat(k);
            if (ifa.pl_trdy) begin exp_q.push_back(beat(k)); k++; end
            step();
        end
        chk("bp_accepted", 64'(k), 64'd4);
        chk("bp_trdy_full", 64'(ifa.pl_trdy), 64'h0);
        chk("bp_head", tx_data, beat(0));
        ifa.lp_data = beat(k);
        tx_ready = 1'b1; pops = 0;
        for (int c = 0; c < 6; c++) begin
            if (tx_valid) begin chk("bp_order", tx_data, exp_q.pop_front()); pops++; end
            if (ifa.pl_trdy && ifa.lp_valid) begin exp_q.push_back(ifa.lp_data); k++; end
            step();
            if (c == 0) chk("bp_trdy_after_pop", 64'(ifa.pl_trdy), 64'h1);
            ifa.lp_valid = k < 6;
            ifa.lp_data = beat(k);
        end
        chk("bp_pops", 64'(pops), 64'd6);
        chk("bp_drained", 64'(tx_valid), 64'h0);

        // Retrain with 2 queued beats
        tx_ready = 1'b0;
        ifa.lp_valid = 1'b1; ifa.lp_data = 64'hE0; exp_q.push_back(64'hE0);
        step();
        ifa.lp_data = 64'hE1; exp_q.push_back(64'hE1);
        step();
        ifa.lp_valid = 1'b0;
        ifa.lp_state_req = 4'hB;
        step();
        ifa.lp_state_req = 4'h0;
        chk("rt_stallreq", 64'(ifa.pl_stallreq), 64'h1);
        chk("rt_trdy", 64'(ifa.pl_trdy), 64'h0);
        chk("rt_sts_stall", 64'(ifa.pl_state_sts), 64'h1);
        tx_ready = 1'b1; pops = 0;
        for (int c = 0; c < 5; c++) begin
            if (tx_valid) begin chk("rt_order", tx_data, exp_q.pop_front()); pops++; end
            step();
        end
        chk("rt_stall_held", 64'(ifa.pl_stallreq), 64'h1);
        chk("rt_pops", 64'(pops), 64'd2);
        ifa.lp_stallack = 1'b1;
        step();
        ifa.lp_stallack = 1'b0;
        chk("rt_sts_retrain", 64'(ifa.pl_state_sts), 64'hB);
        chk("rt_stall_drop", 64'(ifa.pl_stallreq), 64'h0);
        chk("rt_start", 64'(train_start), 64'h1);
        chk("rt_recenter", 64'(ifa.pl_phyinrecenter), 64'h1);
        train_done = 1'b1;
        step();
        train_done = 1'b0;
        chk("rt_sts_active", 64'(ifa.pl_state_sts), 64'h1);

        // Asynchronous reset discards queued beats
        tx_ready = 1'b0;
        ifa.lp_valid = 1'b1; ifa.lp_data = 64'hF0;
        step();
        step();
        ifa.lp_valid = 1'b0;
        chk("ar_queued", 64'(tx_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("ar_txv", 64'(tx_valid), 64'h0);
        chk("ar_sts", 64'(ifa.pl_state_sts), 64'h0);
        step();
        rst_n = 1'b1;
        ifa.lp_state_req = 4'h1;
        step();
        ifa.lp_state_req = 4'h0; train_done = 1'b1;
        step();
        train_done = 1'b0;
        chk("ar_rebring", 64'(ifa.pl_state_sts), 64'h1);

        // Link error during STALL with a full FIFO
        ifa.lp_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin ifa.lp_data = 64'(c); step(); end
        ifa.lp_valid = 1'b0;
        chk("le_full", 64'(ifa.pl_trdy), 64'h0);
        ifa.lp_state_req = 4'hB;
        step();
        chk("le_stall", 64'(ifa.pl_stallreq), 64'h1);
        ifa.lp_linkerror = 1'b1;
        step();
        chk("le_sts", 64'(ifa.pl_state_sts), 64'hA);
        chk("le_flush", 64'(tx_valid), 64'h0);
        chk("le_stallreq", 64'(ifa.pl_stallreq), 64'h0);
        chk("le_trdy", 64'(ifa.pl_trdy), 64'h0);
        ifa.lp_linkerror = 1'b0;
        step();
        chk("le_hold", 64'(ifa.pl_state_sts), 64'hA);
        ifa.lp_state_req = 4'h0;
        step();
        chk("le_exit", 64'(ifa.pl_state_sts), 64'h0);

        // Link error beats same-cycle training completion
        ifa.lp_state_req = 4'h1;
        step();
        ifa.lp_state_req = 4'h0; train_done = 1'b1; ifa.lp_linkerror = 1'b1;
        step();
        train_done = 1'b0; ifa.lp_linkerror = 1'b0;
        chk("pri_sts", 64'(ifa.pl_state_sts), 64'hA);
        step();
        chk("pri_exit", 64'(ifa.pl_state_sts), 64'h0);

        // Training timeout with TRAIN_TIMEOUT=16
        ifb.lp_state_req = 4'h1;
        step();
        ifb.lp_state_req = 4'h0;
        chk("to_start", 64'(b_train_start), 64'h1);
        first_a = 0; pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ifb.pl_state_sts == 4'hA && first_a == 0) first_a = c;
            pulses += int'(ifb.pl_trainerror);
        end
        chk("to_cycle", 64'(first_a), 64'd16);
        chk("to_pulses", 64'(pulses), 64'd1);
        step();
        chk("to_exit", 64'(ifb.pl_state_sts), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
